// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder.sv
// 1-bit full-adder cell. E inverts B so the same cell serves add and subtract.
module adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  input  logic E,
  output logic CO,
  output logic S
);

  logic w_bx;

  // Sum and carry of A + (B ^ E) + CI.
  always_comb begin
    w_bx = B ^ E;
    S    = A ^ w_bx ^ CI;
    CO   = (A & w_bx) | (CI & (A ^ w_bx));
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one operand bit per clock through a
// single full-adder cell, LSB first, with a registered carry between bits.
// Optional abort input in RUN is enabled by defining SERIAL_ADDSUB_ABORT_EN.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one bit per cycle through the adder cell, counter 0..WIDTH-1
//   DONE  | one-cycle done pulse, result/cout/overflow just updated
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_M1   = CNT_W'(WIDTH - 2);

  addsub_state_t r_state;
  addsub_state_t w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  // Holds the WIDTH-1 sum bits already produced; the current bit completes it.
  logic [WIDTH-2:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_sub_q;
  logic             r_c_msb;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_co;
  logic             w_s;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_load;
  logic             w_step;
  logic             w_abort;
  logic             w_last;

  adder u_adder (
    .A  (r_sa[0]),
    .B  (r_sb[0]),
    .CI (r_carry),
    .E  (r_sub_q),
    .CO (w_co),
    .S  (w_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN: begin
        if (w_abort)     w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from state.
  always_comb begin
    busy   = (r_state != IDLE);
    done   = (r_state == DONE);
    w_load = (r_state == IDLE) && start;
`ifdef SERIAL_ADDSUB_ABORT_EN
    w_abort = (r_state == RUN) && abort;
`else
    w_abort = 1'b0;
`endif
    w_step     = (r_state == RUN) && !w_abort;
    w_last     = (r_cnt == LAST_BIT);
    w_sum_next = {w_s, r_sum};
  end

  // Operand shifters, carry chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub_q  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_sa    <= a;
      r_sb    <= b;
      r_sub_q <= sub;
      // Subtract is A + ~B + 1; the +1 enters as the initial carry.
      r_carry <= (sub == OP_SUB);
      r_cnt   <= '0;
    end else if (w_abort) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_carry <= w_co;
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_sum   <= w_sum_next[WIDTH-1:1];
      r_cnt   <= r_cnt + CNT_W'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB.
      if (r_cnt == MSB_M1) r_c_msb <= w_co;
      if (w_last) begin
        r_result <= w_sum_next;
        r_cout   <= w_co;
        r_ovf    <= r_c_msb ^ w_co;
        r_cnt    <= '0;
      end
    end
  end

  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8) against an
// integer-arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef SERIAL_ADDSUB_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] last_res = '0;
  logic         last_co  = 1'b0;
  logic         last_ov  = 1'b0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] r, output logic co, output logic ov);
    int ux, uy, sx, sy, ud, sd;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    if (s) begin
      ud = ux - uy;
      sd = sx - sy;
      co = (ux >= uy);
    end else begin
      ud = ux + uy;
      sd = sx + sy;
      co = (ud >= (1 << W));
    end
    r  = W'(ud);
    ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  // One full operation; glitch injects a start with a=0xAA in the 3rd RUN cycle.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit glitch);
    logic [W-1:0] er;
    logic eco, eov;
    int ndone = 0;
    int lat = -1;
    model(x, y, s, er, eco, eov);
    wait_idle();
    a = x; b = y; sub = s; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      step();
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      if (cyc == 1) check("busy_run", 32'(busy), 32'd1);
      if (cyc == W / 2) check("hold_mid", 32'(result), 32'(last_res));
      if (cyc == W + 1) check("idle_after", 32'(busy), 32'd0);
      if (glitch && cyc == 2) begin
        start = 1'b1;
        a = 8'hAA;
      end
    end
    check("latency", 32'(lat), 32'(W));
    check("done_count", 32'(ndone), 32'd1);
    check("result", 32'(result), 32'(er));
    check("cout", 32'(cout), 32'(eco));
    check("overflow", 32'(overflow), 32'(eov));
    last_res = er; last_co = eco; last_ov = eov;
  endtask

  initial begin
    int nd;
    // Reset state.
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();

    // Directed vectors.
    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 1'b1, 1'b0);
    run_op(8'h55, 8'h55, 1'b1, 1'b0);
    // Start during RUN is ignored.
    run_op(8'h01, 8'h01, 1'b0, 1'b1);

    // Reset in the middle of RUN.
    wait_idle();
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_cout", 32'(cout), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    nd = 0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (done) nd++;
    end
    check("mrst_nodone", 32'(nd), 32'd0);
    last_res = '0; last_co = 1'b0; last_ov = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_ADDSUB_ABORT_EN
    run_op(8'h05, 8'h06, 1'b0, 1'b0);
    wait_idle();
    a = 8'h20; b = 8'h20; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'h0B);
    nd = 0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (done) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);
    check("abort_hold", 32'(result), 32'h0B);
    run_op(8'h10, 8'h20, 1'b1, 1'b0);
`endif

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
